mc_decn_cnt: RTL and testbench

//  Loadable down-counter for memory-controller burst/refresh/timing counts; counterpart of the pipelined incrementer.

---
 rtl/mc_decn_cnt_pkg.sv | 28 ++
 rtl/mc_decn_cnt.sv | 81 ++++++++
 tb/tb_mc_decn_cnt.sv | 175 +++++++++++++++++
 3 files changed

// File: rtl/mc_decn_cnt_pkg.sv
// Shared types for the split-borrow down-counter: the per-cycle operation
// selected from the load/decrement controls and the current zero state.
package mc_decn_cnt_pkg;

  localparam int unsigned DECN_DEF_WIDTH = 32;

  typedef enum logic [1:0] {
    OP_IDLE = 2'd0,  // no request; fold any pending borrow
    OP_LOAD = 2'd1,  // take ld_val, clear borrow
    OP_DEC  = 2'd2,  // count down by one (includes wrap from zero)
    OP_HOLD = 2'd3   // dec at zero while saturating
  } decn_op_e;

  // Load has priority over dec; a dec at zero becomes a wrap or a hold.
  function automatic decn_op_e decn_decode(input logic ld,
                                           input logic dec,
                                           input logic at_zero,
                                           input logic wrap);
    decn_op_e op;
    op = OP_IDLE;
    if (ld)
      op = OP_LOAD;
    else if (dec)
      op = (at_zero && !wrap) ? OP_HOLD : OP_DEC;
    return op;
  endfunction

endpackage

// File: rtl/mc_decn_cnt.sv
// Loadable down-counter: low half decremented and registered, borrow folded
// into the high half on the output path so cnt is the true count every cycle.
module mc_decn_cnt
  import mc_decn_cnt_pkg::*;
#(
  parameter int unsigned DECN_WIDTH  = DECN_DEF_WIDTH,
  parameter int unsigned DECN_CENTER = DECN_WIDTH / 2,
  parameter bit          DECN_WRAP   = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld,
  input  logic [DECN_WIDTH-1:0] ld_val,
  input  logic                  dec,
  output logic [DECN_WIDTH-1:0] cnt,
  output logic                  zero,
  output logic                  tc
);

  localparam int unsigned HI_W = DECN_WIDTH - DECN_CENTER;

  logic [DECN_CENTER-1:0] lo_r;
  logic [HI_W-1:0]        hi_r;
  logic                   brw_r;
  logic                   zero_r;
  logic                   tc_r;

  logic [HI_W-1:0]        hi_fold;
  logic                   at_one;
  decn_op_e               op;

  assign hi_fold = hi_r - HI_W'(brw_r);
  assign cnt     = {hi_fold, lo_r};
  assign zero    = zero_r;
  assign tc      = tc_r;

  // A pending borrow implies lo_r is all-ones, so cnt==1 needs only the raw
  // registers; this keeps the high-half subtract off the flag path.
  assign at_one = (lo_r == DECN_CENTER'(1)) && (hi_r == '0) && !brw_r;

  assign op = decn_decode(ld, dec, zero_r, DECN_WRAP);

  // NOTE: sequential state uses non-blocking assignments only, and the
  // synchronous reset is the first branch so it overrides ld/dec.
  always_ff @(posedge clk) begin
    if (rst) begin
      lo_r   <= '0;
      hi_r   <= '0;
      brw_r  <= 1'b0;
      zero_r <= 1'b1;
      tc_r   <= 1'b0;
    end else begin
      unique case (op)
        OP_LOAD: begin
          lo_r   <= ld_val[DECN_CENTER-1:0];
          hi_r   <= ld_val[DECN_WIDTH-1:DECN_CENTER];
          brw_r  <= 1'b0;
          zero_r <= (ld_val == '0);
          tc_r   <= 1'b0;
        end
        OP_DEC: begin
          // From zero this yields lo=all-ones with a borrow on hi=0: all-ones.
          lo_r   <= lo_r - DECN_CENTER'(1);
          brw_r  <= (lo_r == '0);
          hi_r   <= hi_fold;
          zero_r <= at_one;
          tc_r   <= at_one;
        end
        OP_HOLD: begin
          tc_r <= 1'b0;
        end
        default: begin
          hi_r  <= hi_fold;
          brw_r <= 1'b0;
          tc_r  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mc_decn_cnt.sv
// Self-checking bench: a saturating and a wrapping counter share stimulus and
// are compared every cycle against an integer-level model of the count rules.
module tb_mc_decn_cnt;

  localparam int W = 32;

  logic         clk;
  logic         rst;
  logic         ld;
  logic [W-1:0] ld_val;
  logic         dec;

  logic [W-1:0] cnt_sat, cnt_wrap;
  logic         zero_sat, zero_wrap;
  logic         tc_sat, tc_wrap;

  int n_checks;
  int n_errors;

  logic [W-1:0] m_cnt  [2];
  bit           m_zero [2];
  bit           m_tc   [2];

  mc_decn_cnt #(.DECN_WIDTH(W), .DECN_WRAP(1'b0)) dut_sat (
    .clk(clk), .rst(rst), .ld(ld), .ld_val(ld_val), .dec(dec),
    .cnt(cnt_sat), .zero(zero_sat), .tc(tc_sat)
  );

  mc_decn_cnt #(.DECN_WIDTH(W), .DECN_WRAP(1'b1)) dut_wrap (
    .clk(clk), .rst(rst), .ld(ld), .ld_val(ld_val), .dec(dec),
    .cnt(cnt_wrap), .zero(zero_wrap), .tc(tc_wrap)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: the count as a plain number, updated from the behavioural rules.
  task automatic model_update(input bit r, input bit l, input logic [W-1:0] v, input bit d);
    for (int w = 0; w < 2; w++) begin
      if (r) begin
        m_cnt[w] = '0; m_zero[w] = 1'b1; m_tc[w] = 1'b0;
      end else if (l) begin
        m_cnt[w] = v; m_zero[w] = (v == 0); m_tc[w] = 1'b0;
      end else if (d) begin
        if (m_cnt[w] != 0) begin
          m_cnt[w]  = m_cnt[w] - 1;
          m_zero[w] = (m_cnt[w] == 0);
          m_tc[w]   = m_zero[w];
        end else if (w == 1) begin
          m_cnt[w] = {W{1'b1}}; m_zero[w] = 1'b0; m_tc[w] = 1'b0;
        end else begin
          m_tc[w] = 1'b0;
        end
      end else begin
        m_tc[w] = 1'b0;
      end
    end
  endtask

  task automatic step(input bit r, input bit l, input logic [W-1:0] v, input bit d);
    rst = r; ld = l; ld_val = v; dec = d;
    @(posedge clk);
    model_update(r, l, v, d);
    #1;
    check("cnt_sat",   cnt_sat,   m_cnt[0]);
    check("zero_sat",  zero_sat,  m_zero[0]);
    check("tc_sat",    tc_sat,    m_tc[0]);
    check("cnt_wrap",  cnt_wrap,  m_cnt[1]);
    check("zero_wrap", zero_wrap, m_zero[1]);
    check("tc_wrap",   tc_wrap,   m_tc[1]);
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, 1'b0);
  endtask

  task automatic do_dec();
    step(1'b0, 1'b0, '0, 1'b1);
  endtask

  task automatic do_ld(input logic [W-1:0] v);
    step(1'b0, 1'b1, v, 1'b0);
  endtask

  logic [W-1:0] rv;
  int           sel;

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b1; ld = 1'b0; ld_val = '0; dec = 1'b0;

    // Reset, then decrements at zero: saturating one holds.
    step(1'b1, 1'b0, '0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    check("rst_cnt",  cnt_sat, 32'h0);
    check("rst_zero", zero_sat, 1'b1);
    check("rst_tc",   tc_sat, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0);
    repeat (3) begin
      step(1'b0, 1'b0, '0, 1'b1);
      check("sat_hold", cnt_sat, 32'h0);
    end

    // Borrow across the split point must never expose a stale high half.
    do_ld(32'h0001_0000);
    do_dec();
    check("brw_first", cnt_sat, 32'h0000_FFFF);
    check("brw_zero",  zero_sat, 1'b0);
    do_dec();
    check("brw_second", cnt_sat, 32'h0000_FFFE);

    // Terminal count on the cycle cnt first reads zero.
    do_ld(32'h0000_0002);
    do_dec();
    check("tc_pre", tc_sat, 1'b0);
    do_dec();
    check("tc_hit", tc_sat, 1'b1);
    check("tc_zero", zero_sat, 1'b1);
    do_dec();
    check("tc_once", tc_sat, 1'b0);

    // Load wins over dec; loading zero flags zero without tc.
    do_ld(32'h0000_0005);
    step(1'b0, 1'b1, 32'h1234_5678, 1'b1);
    check("ld_prio", cnt_sat, 32'h1234_5678);
    step(1'b0, 1'b1, 32'h0, 1'b1);
    check("ld_zero_z", zero_sat, 1'b1);
    check("ld_zero_tc", tc_sat, 1'b0);

    // Wrap from zero, idle, then continue down.
    do_dec();
    check("wrap_cnt", cnt_wrap, 32'hFFFF_FFFF);
    check("wrap_tc",  tc_wrap, 1'b0);
    idle();
    do_dec();
    check("wrap_next", cnt_wrap, 32'hFFFF_FFFE);

    // Reset in the middle of a borrowing burst.
    do_ld(32'h0100_0000);
    repeat (10) do_dec();
    step(1'b1, 1'b0, '0, 1'b1);
    check("midrst_cnt", cnt_sat, 32'h0);
    idle();
    check("midrst_hold", cnt_wrap, 32'h0);

    // Randomized traffic biased toward small values and split-point boundaries.
    repeat (1500) begin
      sel = $urandom_range(0, 4);
      case (sel)
        0:       rv = $urandom;
        1:       rv = $urandom_range(0, 4);
        2:       rv = 32'h0001_0000 * $urandom_range(0, 3) + $urandom_range(0, 2);
        3:       rv = 32'h0;
        default: rv = 32'hFFFF_FFFF;
      endcase
      step(($urandom_range(0, 99) < 2),
           ($urandom_range(0, 99) < 12),
           rv,
           ($urandom_range(0, 99) < 75));
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
